// File: rtl/pwm_pkg.sv
// Shared constants for the PWM duty sequencer: state/mode encodings and defaults.
package pwm_pkg;

  localparam int PWM_DUTY_W = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MANUAL    = 3'd1;
  localparam logic [2:0] ST_RAMP_UP   = 3'd2;
  localparam logic [2:0] ST_HOLD_HI   = 3'd3;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
  localparam logic [2:0] ST_HOLD_LO   = 3'd5;
  localparam logic [2:0] ST_FREEZE    = 3'd6;

  localparam logic [1:0] MODE_MANUAL  = 2'b00;
  localparam logic [1:0] MODE_BREATHE = 2'b01;
  localparam logic [1:0] MODE_SAW     = 2'b10;
  localparam logic [1:0] MODE_FREEZE  = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    MANUAL    = ST_MANUAL,
    RAMP_UP   = ST_RAMP_UP,
    HOLD_HI   = ST_HOLD_HI,
    RAMP_DOWN = ST_RAMP_DOWN,
    HOLD_LO   = ST_HOLD_LO,
    FREEZE    = ST_FREEZE
  } state_t;

  // State entered when a mode is (re)selected.
  function automatic state_t entry_state(input logic [1:0] m);
    case (m)
      MODE_MANUAL: entry_state = MANUAL;
      MODE_FREEZE: entry_state = FREEZE;
      default:     entry_state = RAMP_UP;
    endcase
  endfunction

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Divides period ticks into step events: one step every step_div+1 ticks.
module pwm_tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clear,
  input  logic [DIV_W-1:0] step_div,
  output logic             step
);

  logic [DIV_W-1:0] count;
  logic             wrap;

  // >= so a live step_div reduced below the count wraps at once instead of via 2^DIV_W.
  assign wrap = (count >= step_div);
  assign step = tick && !clear && wrap;

  always_ff @(posedge clk) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (tick)   count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-word source for the PWM: manual value, breathing or sawtooth ramp,
// updated only on PWM period boundaries.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W     = PWM_DUTY_W,
  parameter int DIV_W      = 8,
  parameter int HOLD_STEPS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] manual_duty,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              period_tick,
  output logic [DUTY_W-1:0] duty_out,
  output logic [2:0]        state_out,
  output logic              cycle_done
);

  localparam logic [DUTY_W-1:0] DMAX = '1;
  localparam int HC_W = $clog2(HOLD_STEPS + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_STEPS - 1);

  state_t            state, state_nx;
  logic [DUTY_W-1:0] duty_nx;
  logic [HC_W-1:0]   hold_cnt, hold_nx;
  logic [1:0]        mode_q, mode_nx;
  logic              done_nx, mode_chg, presc_clr, step;

  assign mode_chg  = period_tick && (mode != mode_q);
  // Entering any state from IDLE or a new mode restarts the step cadence.
  assign presc_clr = !en || (period_tick && (mode_chg || state == IDLE));
  assign state_out = state;

  pwm_tick_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (period_tick),
    .clear    (presc_clr),
    .step_div (step_div),
    .step     (step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty_out   <= '0;
      hold_cnt   <= '0;
      mode_q     <= MODE_MANUAL;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nx;
      duty_out   <= duty_nx;
      hold_cnt   <= hold_nx;
      mode_q     <= mode_nx;
      cycle_done <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    duty_nx  = duty_out;
    hold_nx  = hold_cnt;
    mode_nx  = mode_q;
    done_nx  = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      duty_nx  = '0;
      hold_nx  = '0;
    end else if (period_tick) begin
      mode_nx = mode;
      if (state == IDLE || mode_chg) begin
        state_nx = entry_state(mode);
        hold_nx  = '0;
        if (mode == MODE_MANUAL) duty_nx = manual_duty;
      end else begin
        case (state)
          MANUAL: duty_nx = manual_duty;
          RAMP_UP: if (step) begin
            if (mode_q == MODE_SAW) begin
              if (duty_out == DMAX) begin
                duty_nx = '0;
                done_nx = 1'b1;
              end else duty_nx = duty_out + 1'b1;
            end else begin
              // Breathe enters HOLD_HI on the step that reaches (or sits at) DMAX.
              if (duty_out != DMAX) duty_nx = duty_out + 1'b1;
              if (duty_out >= DMAX - 1'b1) begin
                state_nx = HOLD_HI;
                hold_nx  = '0;
              end
            end
          end
          RAMP_DOWN: if (step) begin
            if (duty_out != '0) duty_nx = duty_out - 1'b1;
            if (duty_out <= DUTY_W'(1)) begin
              state_nx = HOLD_LO;
              hold_nx  = '0;
            end
          end
          HOLD_HI, HOLD_LO: if (step) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_nx  = '0;
              state_nx = (state == HOLD_HI) ? RAMP_DOWN : RAMP_UP;
              done_nx  = (state == HOLD_LO);
            end else hold_nx = hold_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: reset, manual, breathe, sawtooth divider,
// mode changes and enable drop, with hand-computed expectations.
module tb_pwm_duty_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_MANUAL = 3'd1, S_UP = 3'd2, S_HHI = 3'd3,
                         S_DOWN = 3'd4, S_HLO = 3'd5, S_FRZ = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n, en, period_tick;
  logic [1:0] mode;
  logic [3:0] manual_duty;
  logic [7:0] step_div;
  logic [3:0] duty_out;
  logic [2:0] state_out;
  logic       cycle_done;

  int checks = 0;
  int errors = 0;

  pwm_duty_sequencer #(.DUTY_W(4), .DIV_W(8), .HOLD_STEPS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .manual_duty (manual_duty),
    .step_div    (step_div),
    .period_tick (period_tick),
    .duty_out    (duty_out),
    .state_out   (state_out),
    .cycle_done  (cycle_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] d, input logic [2:0] s, input logic c);
    chk({tag, ".duty"}, 32'(duty_out), 32'(d));
    chk({tag, ".state"}, 32'(state_out), 32'(s));
    chk({tag, ".done"}, 32'(cycle_done), 32'(c));
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled there too.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    period_tick = 1'b1;
    cyc(1);
    period_tick = 1'b0;
  endtask

  initial begin
    logic [3:0] ed;
    logic [2:0] es;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; manual_duty = 4'd0;
    step_div = 8'd0; period_tick = 1'b1;
    cyc(3);
    chk3("reset", 4'd0, S_IDLE, 1'b0);

    rst_n = 1'b1; period_tick = 1'b0; en = 1'b1; manual_duty = 4'd9;
    cyc(2);
    chk3("idle_no_tick", 4'd0, S_IDLE, 1'b0);

    tick();
    chk3("manual_9", 4'd9, S_MANUAL, 1'b0);
    manual_duty = 4'd3;
    cyc(2);
    chk("manual_hold_between", 32'(duty_out), 32'd9);
    tick();
    chk("manual_3", 32'(duty_out), 32'd3);
    manual_duty = 4'd0;
    tick();
    chk("manual_0", 32'(duty_out), 32'd0);

    // Mode change to breathe: step would be due but must not occur.
    mode = 2'b01;
    tick();
    chk3("breathe_enter", 4'd0, S_UP, 1'b0);
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (i <= 15)      ed = 4'(i);
      else if (i <= 18) ed = 4'd15;
      else if (i <= 33) ed = 4'(33 - i);
      else              ed = 4'd0;
      if (i < 15)       es = S_UP;
      else if (i < 18)  es = S_HHI;
      else if (i < 33)  es = S_DOWN;
      else if (i < 36)  es = S_HLO;
      else              es = S_UP;
      chk3($sformatf("breathe_t%0d", i), ed, es, (i == 36));
    end
    cyc(1);
    chk("breathe_done_clear", 32'(cycle_done), 32'd0);

    repeat (7) tick();
    chk("breathe_at7", 32'(duty_out), 32'd7);
    step_div = 8'd1;
    mode = 2'b11;
    tick();
    chk3("freeze_enter", 4'd7, S_FRZ, 1'b0);
    repeat (3) tick();
    chk3("freeze_hold", 4'd7, S_FRZ, 1'b0);
    mode = 2'b01;
    tick();
    chk3("rebreathe_enter", 4'd7, S_UP, 1'b0);
    tick();
    chk("rebreathe_presc_cleared", 32'(duty_out), 32'd7);
    tick();
    chk("rebreathe_step", 32'(duty_out), 32'd8);

    // Sawtooth with divide-by-3 from duty 8.
    step_div = 8'd2;
    mode = 2'b10;
    tick();
    chk3("saw_enter", 4'd8, S_UP, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      ed = (k == 24) ? 4'd0 : 4'(8 + k / 3);
      chk3($sformatf("saw_k%0d", k), ed, S_UP, (k == 24));
    end
    cyc(1);
    chk("saw_done_one_clk", 32'(cycle_done), 32'd0);

    step_div = 8'd0;
    tick();
    tick();
    chk("saw_at2", 32'(duty_out), 32'd2);
    en = 1'b0;
    cyc(1);
    chk3("en_drop", 4'd0, S_IDLE, 1'b0);
    en = 1'b1;
    cyc(2);
    chk("en_back_wait_tick", 32'(state_out), 32'(S_IDLE));
    tick();
    chk3("resume_saw", 4'd0, S_UP, 1'b0);
    tick();
    chk("resume_step", 32'(duty_out), 32'd1);

    rst_n = 1'b0;
    cyc(1);
    chk3("reset_mid", 4'd0, S_IDLE, 1'b0);
    rst_n = 1'b1;
    mode = 2'b00; manual_duty = 4'd12;
    tick();
    chk3("post_reset_manual", 4'd12, S_MANUAL, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
